// File: rtl/jt6295_pkg.sv
// jt6295_pkg: shared constants, FSM state type and byte-select helper for
// the ADPCM sample-ROM responder. JT6295_ROM_PREFETCH_EN adds the PREF state.
package jt6295_pkg;

  localparam int JT6295_ROM_AW = 18;
  localparam int JT6295_MEM_DW = 16;

`ifdef JT6295_ROM_PREFETCH_EN
  typedef enum logic [1:0] {IDLE, WAIT, PREF} jt6295_state_e;
`else
  typedef enum logic {IDLE, WAIT} jt6295_state_e;
`endif

  // le=1: even byte address takes the low byte; le=0: even takes the high byte
  function automatic logic [7:0] jt6295_byte_sel(input logic [JT6295_MEM_DW-1:0] word,
                                                 input logic odd, input bit le);
    return (odd ^ le) ? word[7:0] : word[15:8];
  endfunction

endpackage

// File: rtl/jt6295_rom_resp_if.sv
// jt6295_rom_resp_if: byte-side (arbiter) and word-side (memory controller)
// signals of the sample-ROM responder. The slave modport is the responder.
interface jt6295_rom_resp_if #(
  parameter int AW = jt6295_pkg::JT6295_ROM_AW
) ();
  import jt6295_pkg::*;

  logic [AW-1:0]            rom_addr;
  logic [7:0]               rom_data;
  logic                     rom_ok;
  logic                     mem_req;
  logic [AW-2:0]            mem_addr;
  logic [JT6295_MEM_DW-1:0] mem_data;
  logic                     mem_ack;

  modport slave (
    input  rom_addr, mem_data, mem_ack,
    output rom_data, rom_ok, mem_req, mem_addr
  );

  modport master (
    output rom_addr, mem_data, mem_ack,
    input  rom_data, rom_ok, mem_req, mem_addr
  );

endinterface

// File: rtl/jt6295_rom_line.sv
// jt6295_rom_line: one buffered memory word with its tag and valid bit,
// plus the hit compare and byte select against the current byte address.
module jt6295_rom_line
  import jt6295_pkg::*;
#(
  parameter int AW = JT6295_ROM_AW,
  parameter bit LE = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     load,
  input  logic                     inval,
  input  logic [AW-2:0]            load_tag,
  input  logic [JT6295_MEM_DW-1:0] load_data,
  input  logic [AW-1:0]            rom_addr,
  output logic                     hit,
  output logic [7:0]               rd_byte
);

  logic [JT6295_MEM_DW-1:0] data_q, data_d;
  logic [AW-2:0]            tag_q, tag_d;
  logic                     valid_q, valid_d;

  // A load wins over an invalidate; the data and tag only change on a load
  always_comb begin
    data_d  = data_q;
    tag_d   = tag_q;
    valid_d = valid_q;
    if (load) begin
      data_d  = load_data;
      tag_d   = load_tag;
      valid_d = 1'b1;
    end else if (inval) begin
      valid_d = 1'b0;
    end
  end

  // Line storage, cleared on reset so the byte output reads zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= '0;
      tag_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      tag_q   <= tag_d;
      valid_q <= valid_d;
    end
  end

  assign hit     = valid_q && (rom_addr[AW-1:1] == tag_q);
  assign rd_byte = jt6295_byte_sel(data_q, rom_addr[0], LE);

endmodule

// File: rtl/jt6295_rom_resp.sv
// jt6295_rom_resp: responder for the ADPCM sample-ROM byte interface.
// Serves bytes from a buffered 16-bit word and fetches missing words over a
// level req/ack handshake. Define JT6295_ROM_PREFETCH_EN for a second line
// that prefetches the next word; the two lines swap roles on a promotion.
module jt6295_rom_resp
  import jt6295_pkg::*;
#(
  parameter int AW = JT6295_ROM_AW,
  parameter bit LE = 1'b1
) (
  input logic              clk,
  input logic              rst_n,
  jt6295_rom_resp_if.slave bus
);

  localparam int WW = AW - 1;

  jt6295_state_e state_q, state_d;
  logic          mem_req_q, mem_req_d;
  logic [WW-1:0] mem_addr_q, mem_addr_d;

  logic       load0, inval0, hit0;
  logic [7:0] byte0;
  logic       hit;

  jt6295_rom_line #(.AW(AW), .LE(LE)) u_line0 (
    .clk(clk), .rst_n(rst_n), .load(load0), .inval(inval0),
    .load_tag(mem_addr_q), .load_data(bus.mem_data), .rom_addr(bus.rom_addr),
    .hit(hit0), .rd_byte(byte0)
  );

`ifdef JT6295_ROM_PREFETCH_EN
  logic          load1, inval1, hit1;
  logic [7:0]    byte1;
  logic          sel_q, sel_d;
  logic          pend_q, pend_d;
  logic [WW-1:0] pf_word_q, pf_word_d;
  logic          hit_prim, hit_sec;

  jt6295_rom_line #(.AW(AW), .LE(LE)) u_line1 (
    .clk(clk), .rst_n(rst_n), .load(load1), .inval(inval1),
    .load_tag(mem_addr_q), .load_data(bus.mem_data), .rom_addr(bus.rom_addr),
    .hit(hit1), .rd_byte(byte1)
  );

  assign hit_prim     = sel_q ? hit1 : hit0;
  assign hit_sec      = sel_q ? hit0 : hit1;
  assign hit          = hit0 | hit1;
  assign bus.rom_data = hit0 ? byte0 : byte1;
`else
  assign hit          = hit0;
  assign bus.rom_data = byte0;
`endif

  assign bus.rom_ok   = hit;
  assign bus.mem_req  = mem_req_q;
  assign bus.mem_addr = mem_addr_q;

  // Next-state and line control; a request once raised is held until ack
  always_comb begin
    state_d    = state_q;
    mem_req_d  = mem_req_q;
    mem_addr_d = mem_addr_q;
    load0      = 1'b0;
    inval0     = 1'b0;
`ifdef JT6295_ROM_PREFETCH_EN
    load1      = 1'b0;
    inval1     = 1'b0;
    sel_d      = sel_q;
    pend_d     = pend_q;
    pf_word_d  = pf_word_q;
`endif
    case (state_q)
      IDLE: begin
        if (!hit) begin
          state_d    = WAIT;
          mem_req_d  = 1'b1;
          mem_addr_d = bus.rom_addr[AW-1:1];
          inval0     = 1'b1;
`ifdef JT6295_ROM_PREFETCH_EN
          inval1     = 1'b1;
          pend_d     = 1'b0;
`endif
        end
`ifdef JT6295_ROM_PREFETCH_EN
        else if (hit_sec && !hit_prim) begin
          sel_d     = ~sel_q;
          pf_word_d = pf_word_q + WW'(1);
          pend_d    = 1'b1;
        end else if (pend_q) begin
          state_d    = PREF;
          mem_req_d  = 1'b1;
          mem_addr_d = pf_word_q;
          pend_d     = 1'b0;
          if (sel_q) inval0 = 1'b1;
          else       inval1 = 1'b1;
        end
`endif
      end
      WAIT: begin
        if (bus.mem_ack) begin
          state_d   = IDLE;
          mem_req_d = 1'b0;
`ifdef JT6295_ROM_PREFETCH_EN
          if (sel_q) load1 = 1'b1;
          else       load0 = 1'b1;
          pf_word_d = mem_addr_q + WW'(1);
          pend_d    = 1'b1;
`else
          load0     = 1'b1;
`endif
        end
      end
`ifdef JT6295_ROM_PREFETCH_EN
      PREF: begin
        if (bus.mem_ack) begin
          state_d   = IDLE;
          mem_req_d = 1'b0;
          if (hit_prim) begin
            if (sel_q) load0 = 1'b1;
            else       load1 = 1'b1;
          end
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  // FSM and request registers; reset drops the request immediately
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
    end
  end

`ifdef JT6295_ROM_PREFETCH_EN
  // Prefetch bookkeeping: primary line select, pending flag, next word
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q     <= 1'b0;
      pend_q    <= 1'b0;
      pf_word_q <= '0;
    end else begin
      sel_q     <= sel_d;
      pend_q    <= pend_d;
      pf_word_q <= pf_word_d;
    end
  end
`endif

endmodule
